// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared state encodings and constants for the countdown timer
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/seconds_down_counter.sv
// rtl/seconds_down_counter.sv - mod-60 seconds down counter with borrow out
module seconds_down_counter
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [5:0] ld_val,
  output logic [5:0] count,
  output logic       borrow
);

  logic [5:0] r_count;

  assign count  = r_count;
  assign borrow = en & (r_count == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 6'd0;
    end else if (ld) begin
      r_count <= ld_val;
    end else if (en) begin
      r_count <= (r_count == 6'd0) ? SEC_MAX : r_count - 6'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - preset minutes:seconds countdown timer driven by a 1 Hz tick strobe
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       busy,
  output logic       expired,
  output logic       load_err
);

  localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);

  state_t     r_state;
  logic [5:0] r_min;
  logic       r_busy;
  logic       r_expired;
  logic       r_load_err;

  state_t     w_state_nxt;
  logic       w_sec_ld;
  logic [5:0] w_sec_ld_val;
  logic [5:0] w_min_ld_val;
  logic       w_sec_en;
  logic       w_expired_nxt;
  logic       w_load_err_nxt;
  logic [5:0] w_sec;
  logic       w_borrow;
  logic       w_load_ok;
  logic       w_zero;
  logic       w_one;

  assign w_load_ok = (load_sec <= SEC_MAX) && (load_min <= MAX_MIN_V);
  assign w_zero    = (r_min == 6'd0) && (w_sec == 6'd0);
  assign w_one     = (r_min == 6'd0) && (w_sec == 6'd1);

  seconds_down_counter u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_sec_en),
    .ld     (w_sec_ld),
    .ld_val (w_sec_ld_val),
    .count  (w_sec),
    .borrow (w_borrow)
  );

  // Commands are strictly prioritised: a lower one is dropped whenever a higher one is present,
  // even if the higher one ends up ignored in the current state.
  always_comb begin
    w_state_nxt    = r_state;
    w_sec_ld       = 1'b0;
    w_sec_ld_val   = load_sec;
    w_min_ld_val   = load_min;
    w_sec_en       = 1'b0;
    w_expired_nxt  = 1'b0;
    w_load_err_nxt = 1'b0;
    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_sec_ld     = 1'b1;
      w_sec_ld_val = 6'd0;
      w_min_ld_val = 6'd0;
    end else if (load) begin
      if (r_state == ST_IDLE || r_state == ST_DONE) begin
        if (w_load_ok) begin
          w_state_nxt = ST_IDLE;
          w_sec_ld    = 1'b1;
        end else begin
          w_load_err_nxt = 1'b1;
        end
      end
    end else if (start) begin
      if ((r_state == ST_IDLE && !w_zero) || r_state == ST_PAUSED) begin
        w_state_nxt = ST_RUN;
      end
    end else if (pause) begin
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_PAUSED;
      end
    end else if (tick && r_state == ST_RUN) begin
      w_sec_en = 1'b1;
      if (w_one) begin
        w_state_nxt   = ST_DONE;
        w_expired_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_min      <= 6'd0;
      r_busy     <= 1'b0;
      r_expired  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sec_ld) begin
        r_min <= w_min_ld_val;
      end else if (w_borrow) begin
        r_min <= r_min - 6'd1;
      end
      r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSED);
      r_expired  <= w_expired_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign min      = r_min;
  assign sec      = w_sec;
  assign busy     = r_busy;
  assign expired  = r_expired;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer against a total-seconds reference model
module tb_countdown_timer;

  localparam int TB_MAX_MIN = 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  typedef struct {
    logic [5:0] min;
    logic [5:0] sec;
    logic       busy;
    logic       expired;
    logic       load_err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [5:0] load_min = 6'd0, load_sec = 6'd0;
  logic [5:0] min, sec;
  logic       busy, expired, load_err;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  int   m_state = M_IDLE;
  int   m_t = 0;

  countdown_timer #(.MAX_MIN(TB_MAX_MIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .min      (min),
    .sec      (sec),
    .busy     (busy),
    .expired  (expired),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("min", int'(min), int'(e.min));
    check("sec", int'(sec), int'(e.sec));
    check("busy", int'(busy), int'(e.busy));
    check("expired", int'(expired), int'(e.expired));
    check("load_err", int'(load_err), int'(e.load_err));
  endtask

  // Monitor: outputs settle just after each edge; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e);
      end
    end
  end

  // Drive one cycle of commands and push the behaviour the reference model predicts.
  task automatic cyc(input bit ab, input bit ld, input int lm, input int ls,
                     input bit st, input bit pa, input bit tk);
    exp_t e;
    bit   m_exp = 1'b0;
    bit   m_err = 1'b0;
    abort = ab; load = ld; load_min = 6'(lm); load_sec = 6'(ls);
    start = st; pause = pa; tick = tk;
    if (ab) begin
      m_state = M_IDLE;
      m_t = 0;
    end else if (ld) begin
      if (m_state == M_IDLE || m_state == M_DONE) begin
        if (ls > 59 || lm > TB_MAX_MIN) m_err = 1'b1;
        else begin
          m_t = lm * 60 + ls;
          m_state = M_IDLE;
        end
      end
    end else if (st) begin
      if ((m_state == M_IDLE && m_t != 0) || m_state == M_PAUSED) m_state = M_RUN;
    end else if (pa) begin
      if (m_state == M_RUN) m_state = M_PAUSED;
    end else if (tk && m_state == M_RUN) begin
      m_t = m_t - 1;
      if (m_t == 0) begin
        m_state = M_DONE;
        m_exp = 1'b1;
      end
    end
    e.min      = 6'(m_t / 60);
    e.sec      = 6'(m_t % 60);
    e.busy     = (m_state == M_RUN) || (m_state == M_PAUSED);
    e.expired  = m_exp;
    e.load_err = m_err;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int lm, input int ls);
    cyc(0, 1, lm, ls, 0, 0, 0);
  endtask

  task automatic do_start();
    cyc(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_tick();
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    exp_t zero_e;
    zero_e.min = 6'd0; zero_e.sec = 6'd0; zero_e.busy = 1'b0;
    zero_e.expired = 1'b0; zero_e.load_err = 1'b0;

    #3;
    check_all(zero_e);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    do_load(0, 5);
    do_start();
    repeat (5) do_tick();
    repeat (2) idle();

    do_load(2, 0);
    do_start();
    do_tick();
    repeat (119) do_tick();
    repeat (2) do_tick();

    do_load(0, 60);
    do_load(TB_MAX_MIN + 1, 0);
    do_load(63, 63);
    idle();

    do_load(0, 10);
    do_start();
    cyc(0, 0, 0, 0, 0, 1, 1);
    repeat (3) do_tick();
    cyc(0, 1, 0, 2, 0, 0, 0);
    do_start();
    do_tick();
    cyc(0, 1, 5, 5, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);

    cyc(1, 0, 0, 0, 0, 0, 0);
    do_load(1, 30);
    do_start();
    cyc(1, 0, 0, 0, 0, 0, 1);
    do_start();
    idle();

    do_load(0, 3);
    do_start();
    do_tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_all(zero_e);
    m_state = M_IDLE;
    m_t = 0;
    abort = 0; load = 0; start = 0; pause = 0; tick = 0;
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    do_load(0, 1);
    do_start();
    do_tick();
    idle();

    for (int i = 0; i < 3000; i++) begin
      bit ab, ld, st, pa, tk;
      int lm, ls;
      ab = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 7);
      st = ($urandom_range(0, 99) < 12);
      pa = ($urandom_range(0, 99) < 6);
      tk = ($urandom_range(0, 99) < 65);
      lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 2));
      ls = ($urandom_range(0, 7) == 0) ? int'($urandom_range(55, 63)) : int'($urandom_range(0, 59));
      cyc(ab, ld, lm, ls, st, pa, tk);
    end

    idle();
    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
